// File: rtl/csa_pkg.sv
// Shared types and helpers for the carry-save stream accumulator.
//   csa_state_e  : control FSM states
//   csa_rows_at  : row count entering a given 3:2 level
//   csa_levels   : number of 3:2 levels needed to reach two rows
//   csa_ext      : sign/zero extension of an operand up to CSA_MAX_W bits
package csa_pkg;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    HOLD    = 2'd3
  } csa_state_e;

  // Widest accumulator the extend helper supports.
  localparam int CSA_MAX_W = 64;

  // Each level packs every full group of three rows into two.
  // Leftover rows (rows % 3) pass straight through to the next level.
  function automatic int csa_rows_at(input int rows, input int lvl);
    int n;
    n = rows;
    for (int i = 0; i < lvl; i++) n = 2 * (n / 3) + n % 3;
    return n;
  endfunction

  function automatic int csa_levels(input int rows);
    int n;
    int lv;
    n  = rows;
    lv = 0;
    while (n > 2) begin
      n  = 2 * (n / 3) + n % 3;
      lv = lv + 1;
    end
    return lv;
  endfunction

  // Shift the operand to the top of the word, then shift it back down.
  // An arithmetic shift sign-extends; a logical shift zero-extends.
  function automatic logic [CSA_MAX_W-1:0] csa_ext(input logic [CSA_MAX_W-1:0] v,
                                                   input int in_w, input bit sgn);
    logic [CSA_MAX_W-1:0] t;
    t = v << (CSA_MAX_W - in_w);
    if (sgn) return $unsigned($signed(t) >>> (CSA_MAX_W - in_w));
    else     return t >> (CSA_MAX_W - in_w);
  endfunction

endpackage

// File: rtl/csa_tree.sv
// Purely combinational 3:2 compressor tree.
//   rows_i  : ROWS addends, each ACC_W bits wide
//   sum_o   : redundant sum row
//   carry_o : redundant carry row, already weighted (shifted left by 1)
// The result is sum_o + carry_o == sum(rows_i) mod 2^ACC_W.
module csa_tree
  import csa_pkg::*;
#(
  parameter int ROWS  = 6,
  parameter int ACC_W = 48
) (
  input  logic [ROWS-1:0][ACC_W-1:0] rows_i,
  output logic [ACC_W-1:0]           sum_o,
  output logic [ACC_W-1:0]           carry_o
);

  localparam int LEVELS = csa_levels(ROWS);

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int N_CUR = csa_rows_at(ROWS, l);
    localparam int N_GRP = N_CUR / 3;
    localparam int N_REM = N_CUR % 3;
    localparam int N_NXT = 2 * N_GRP + N_REM;

    logic [N_CUR-1:0][ACC_W-1:0] cur;
    logic [N_NXT-1:0][ACC_W-1:0] nxt;

    if (l == 0) begin : g_src
      assign cur = rows_i;
    end else begin : g_src
      assign cur = g_lvl[l-1].nxt;
    end

    for (genvar g = 0; g < N_GRP; g++) begin : g_cell
      assign nxt[2*g]   = cur[3*g] ^ cur[3*g+1] ^ cur[3*g+2];
      // Majority carries into the next bit position. The carry out of the
      // top bit is dropped, which keeps the wrap modulo 2^ACC_W.
      assign nxt[2*g+1] = ((cur[3*g] & cur[3*g+1]) | (cur[3*g] & cur[3*g+2]) |
                           (cur[3*g+1] & cur[3*g+2])) << 1;
    end

    for (genvar p = 0; p < N_REM; p++) begin : g_pass
      assign nxt[2*N_GRP+p] = cur[3*N_GRP+p];
    end
  end

  assign sum_o   = g_lvl[LEVELS-1].nxt[0];
  assign carry_o = g_lvl[LEVELS-1].nxt[1];

endmodule

// File: rtl/csa_stream_accumulator.sv
// Streaming multi-operand accumulator with a carry-save running total.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : operand beat handshake (in_last marks the packet end)
//   in_data             : NUM_IN operands; operand k is at [k*IN_W +: IN_W]
//   out_valid/out_ready : result handshake
//   out_data            : packet sum mod 2^ACC_W
//   out_beats           : beats in the packet, saturating
// Each beat runs only through the compressor tree. A single adder resolves
// the redundant pair once per packet, in the RESOLVE cycle.
module csa_stream_accumulator
  import csa_pkg::*;
#(
  parameter int IN_W   = 32,
  parameter int NUM_IN = 4,
  parameter int ACC_W  = 48,
  parameter int SIGNED = 1,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_IN*IN_W-1:0] in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_data,
  output logic [CNT_W-1:0]       out_beats
);

  localparam int ROWS = NUM_IN + 2;

  csa_state_e              state_q, state_d;
  logic [ACC_W-1:0]        acc_s_q, acc_s_d, acc_c_q, acc_c_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic [ACC_W-1:0]        out_data_q, out_data_d;
  logic [CNT_W-1:0]        out_beats_q, out_beats_d;

  logic [ROWS-1:0][ACC_W-1:0] rows;
  logic [ACC_W-1:0]           tree_s, tree_c;
  logic                       accept;

  for (genvar k = 0; k < NUM_IN; k++) begin : g_ext
    assign rows[k] = ACC_W'(csa_ext(CSA_MAX_W'(in_data[k*IN_W +: IN_W]), IN_W, SIGNED != 0));
  end
  assign rows[NUM_IN]   = acc_s_q;
  assign rows[NUM_IN+1] = acc_c_q;

  csa_tree #(.ROWS(ROWS), .ACC_W(ACC_W)) u_tree (
    .rows_i  (rows),
    .sum_o   (tree_s),
    .carry_o (tree_c)
  );

  // in_ready_q is only ever high in ACCUM, so it qualifies the accept alone.
  assign accept = in_valid & in_ready_q;

  always_comb begin
    state_d     = state_q;
    acc_s_d     = acc_s_q;
    acc_c_d     = acc_c_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_beats_d = out_beats_q;
    unique case (state_q)
      INIT: state_d = ACCUM;
      ACCUM: if (accept) begin
        acc_s_d = tree_s;
        acc_c_d = tree_c;
        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        if (in_last) state_d = RESOLVE;
      end
      RESOLVE: begin
        out_data_d  = acc_s_q + acc_c_q;
        out_beats_d = cnt_q;
        acc_s_d     = '0;
        acc_c_d     = '0;
        cnt_d       = '0;
        state_d     = HOLD;
      end
      HOLD: if (out_valid_q && out_ready) state_d = ACCUM;
      default: state_d = INIT;
    endcase
    // Both handshake flags are decoded from the registered state. in_ready
    // needs ACCUM on both sides of the edge. This drops it as the last beat
    // is taken, and it gives one bubble cycle after leaving HOLD.
    in_ready_d  = (state_q == ACCUM) && (state_d == ACCUM);
    out_valid_d = (state_q == HOLD) && !(out_valid_q && out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      acc_s_q     <= '0;
      acc_c_q     <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_beats_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_s_q     <= acc_s_d;
      acc_c_q     <= acc_c_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_beats_q <= out_beats_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_beats = out_beats_q;

endmodule
